// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//
// Modulo-N up/down counter with synchronous load, count enable,
// terminal-count pulse and sticky overflow flag. All outputs are registered.
//
// Optional feature macro: MODCNT_SAT_EN
//   defined   -> 'sat' port exists; sat = 1 holds the count at the bound
//                on a boundary event instead of wrapping.
//   undefined -> no 'sat' port; the counter always wraps.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   init     in   load value (clamped to MODULUS-1)
//   set      in   synchronous load strobe
//   en       in   count enable
//   up       in   direction: 1 = increment, 0 = decrement
//   clr_ovf  in   clears the sticky overflow flag
//   sat      in   saturate instead of wrap (MODCNT_SAT_EN only)
//   out      out  current count
//   tc       out  terminal-count pulse, coincides with the post-wrap value
//   ovf      out  sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] init,
    input  logic             set,
    input  logic             en,
    input  logic             up,
    input  logic             clr_ovf,
`ifdef MODCNT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // MODULUS may equal 2^WIDTH, so the load-range compare is done one bit
    // wider than the counter to keep MODULUS representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             at_bound;
    logic             init_ok;
    logic             hold_at_bound;

`ifdef MODCNT_SAT_EN
    assign hold_at_bound = sat;
`else
    assign hold_at_bound = 1'b0;
`endif

    assign at_bound = up ? (out == LAST) : (out == '0);
    assign init_ok  = ({1'b0, init} < MOD_EXT);

    // The plain +1/-1 step is only taken away from the bound, so it can
    // never leave 0..MODULUS-1 and WIDTH bits are sufficient for it.
    always_comb begin
        out_nxt = out;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf & ~clr_ovf;

        if (set) begin
            out_nxt = init_ok ? init : LAST;
        end else if (en) begin
            if (at_bound) begin
                tc_nxt  = 1'b1;
                ovf_nxt = 1'b1;   // a boundary event beats clr_ovf
                if (hold_at_bound) begin
                    out_nxt = out;
                end else begin
                    out_nxt = up ? '0 : LAST;
                end
            end else begin
                out_nxt = up ? (out + ONE) : (out - ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            out <= out_nxt;
            tc  <= tc_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
//
// Two counters (MODULUS = 10 and MODULUS = 16, WIDTH = 4) share one
// stimulus stream. A behavioural model tracks both; a compare process
// checks every cycle on the falling edge, and directed steps add literal
// expectations taken from the hand-worked scenarios.
// ---------------------------------------------------------------------------
module tb_mod_counter;

    typedef struct packed {
        logic [31:0] o;
        logic        tc;
        logic        ovf;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] init = '0;
    logic       set = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       sat_i = 1'b0;

    logic [3:0] o10, o16;
    logic       tc10, tc16, ovf10, ovf16;

    int checks = 0;
    int failures = 0;

    mstate_t m10 = '0;
    mstate_t m16 = '0;
    logic    m_valid = 1'b0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk(clk), .reset_n(reset_n), .init(init), .set(set), .en(en),
        .up(up), .clr_ovf(clr_ovf),
`ifdef MODCNT_SAT_EN
        .sat(sat_i),
`endif
        .out(o10), .tc(tc10), .ovf(ovf10)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16)) u16 (
        .clk(clk), .reset_n(reset_n), .init(init), .set(set), .en(en),
        .up(up), .clr_ovf(clr_ovf),
`ifdef MODCNT_SAT_EN
        .sat(sat_i),
`endif
        .out(o16), .tc(tc16), .ovf(ovf16)
    );

    // Next state from the behavioural rules, using integer arithmetic.
    function automatic mstate_t nxt(mstate_t s, int mod);
        mstate_t r;
        int      cur;
        int      val;
        cur  = int'(s.o);
        r    = s;
        r.tc = 1'b0;
        if (!reset_n) begin
            r = '0;
        end else begin
            if (clr_ovf) r.ovf = 1'b0;
            if (set) begin
                val = int'(init);
                r.o = (val < mod) ? 32'(val) : 32'(mod - 1);
            end else if (en) begin
                if (up && cur == mod - 1) begin
                    r.tc = 1'b1; r.ovf = 1'b1;
                    r.o  = sat_i ? 32'(cur) : 32'd0;
                end else if (!up && cur == 0) begin
                    r.tc = 1'b1; r.ovf = 1'b1;
                    r.o  = sat_i ? 32'd0 : 32'(mod - 1);
                end else begin
                    r.o = up ? 32'(cur + 1) : 32'(cur - 1);
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) m_valid <= 1'b1;
        m10 <= nxt(m10, 10);
        m16 <= nxt(m16, 16);
    end

    task automatic cmp_dut(string nm, mstate_t m, logic [3:0] o, logic t, logic v);
        checks++;
        if (32'(o) !== m.o || t !== m.tc || v !== m.ovf) begin
            failures++;
            $display("FAIL model_%s t=%0t got out=%0d tc=%0b ovf=%0b want out=%0d tc=%0b ovf=%0b",
                     nm, $time, o, t, v, m.o, m.tc, m.ovf);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_dut("m10", m10, o10, tc10, ovf10);
            cmp_dut("m16", m16, o16, tc16, ovf16);
        end
    end

    task automatic lit(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with set/en active
        reset_n = 0; set = 1; en = 1; init = 4'd5; up = 1;
        tick(); tick();
        lit("rst_out", int'(o10), 0);
        lit("rst_tc", int'(tc10), 0);
        lit("rst_ovf", int'(ovf10), 0);
        reset_n = 1; set = 0; en = 1; up = 1;
        tick();
        lit("rel_out", int'(o10), 1);

        // Up wrap, MODULUS 10
        set = 1; init = 4'd8; tick();
        lit("load8", int'(o10), 8);
        set = 0; en = 1; up = 1;
        tick(); lit("up_9", int'(o10), 9); lit("up_9_tc", int'(tc10), 0);
        tick(); lit("up_0", int'(o10), 0); lit("up_0_tc", int'(tc10), 1);
        tick(); lit("up_1", int'(o10), 1); lit("up_1_tc", int'(tc10), 0);
        lit("up_ovf", int'(ovf10), 1);

        // Down wrap and clear
        set = 1; init = 4'd1; tick();
        set = 0; en = 1; up = 0;
        tick(); lit("dn_0", int'(o10), 0); lit("dn_0_tc", int'(tc10), 0);
        tick(); lit("dn_9", int'(o10), 9); lit("dn_9_tc", int'(tc10), 1);
        en = 0; clr_ovf = 1; tick(); clr_ovf = 0;
        lit("clr_ovf", int'(ovf10), 0); lit("clr_hold", int'(o10), 9);

        // Load clamp and priority over en
        set = 1; en = 1; up = 1; init = 4'd13; tick();
        lit("clamp10", int'(o10), 9); lit("clamp_tc", int'(tc10), 0);
        lit("noclamp16", int'(o16), 13);
        set = 0; en = 0; tick();
        lit("hold9", int'(o10), 9);

        // Full range, MODULUS 16
        set = 1; init = 4'd15; tick();
        lit("load15", int'(o16), 15);
        set = 0; en = 1; up = 1; tick();
        lit("fr_0", int'(o16), 0); lit("fr_tc", int'(tc16), 1);
        lit("fr_ovf", int'(ovf16), 1);
        up = 0; clr_ovf = 1; tick(); clr_ovf = 0;
        lit("fr_15", int'(o16), 15); lit("fr_tc2", int'(tc16), 1);
        lit("clr_vs_evt", int'(ovf16), 1);
        en = 0; clr_ovf = 1; tick(); clr_ovf = 0;
        lit("fr_clr", int'(ovf16), 0);

        // Reset mid-count
        en = 1; up = 1; tick();
        reset_n = 0; tick(); reset_n = 1; en = 0;
        lit("midrst_out", int'(o16), 0); lit("midrst_tc", int'(tc16), 0);

`ifdef MODCNT_SAT_EN
        sat_i = 1; set = 1; init = 4'd9; tick();
        set = 0; en = 1; up = 1;
        tick(); lit("sat_9a", int'(o10), 9); lit("sat_tca", int'(tc10), 1);
        tick(); lit("sat_9b", int'(o10), 9); lit("sat_tcb", int'(tc10), 1);
        lit("sat_ovf", int'(ovf10), 1);
        set = 1; init = 4'd0; tick();
        set = 0; up = 0; tick();
        lit("sat_0", int'(o10), 0); lit("sat_tc0", int'(tc10), 1);
        sat_i = 0; en = 0;
`endif

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 29) != 0);
            set     = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up      = $urandom_range(0, 1) == 1;
            clr_ovf = ($urandom_range(0, 9) == 0);
            init    = 4'($urandom_range(0, 15));
`ifdef MODCNT_SAT_EN
            sat_i   = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        reset_n = 1; set = 0; en = 0; clr_ovf = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
